// File: rtl/fifo_flex.sv
// Single-clock synchronous FIFO with arbitrary depth, programmable almost flags,
// sticky error flags and a choice of registered-read or first-word-fall-through output.
module fifo_flex #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 32,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter bit FWFT     = 1'b0,
  localparam int CNTW    = $clog2(DEPTH + 1),
  localparam int PTRW    = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [CNTW-1:0]  count,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;
  logic             wr_accept;
  logic             rd_accept;

  // Pointers wrap at DEPTH-1 explicitly so non-power-of-two depths work.
  function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  assign empty        = (count == '0);
  assign full         = (count == CNTW'(DEPTH));
  assign almost_empty = (count <= CNTW'(AE_LEVEL));
  assign almost_full  = (count >= CNTW'(AF_LEVEL));

  assign wr_accept = wr_en && !full  && !clr;
  assign rd_accept = rd_en && !empty && !clr;

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (rd_accept) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is presented combinationally; masked to zero when nothing is stored.
      assign rd_data  = empty ? '0 : mem[rd_ptr];
      assign rd_valid = !empty;
    end else begin : g_reg
      logic [WIDTH-1:0] rd_data_q;
      logic             rd_valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_accept;
          if (rd_accept) begin
            rd_data_q <= mem[rd_ptr];
          end
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_flex.sv
// Scoreboard bench for fifo_flex: registered-read and FWFT instances share one stimulus stream
// and are compared against a queue model of the FIFO contents.
module tb_fifo_flex;

  localparam int DEPTH = 5;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;

  logic [WIDTH-1:0] rd_data0, rd_data1;
  logic             rd_valid0, rd_valid1;
  logic [2:0]       count0, count1;
  logic             empty0, full0, ae0, af0, ovf0, unf0;
  logic             empty1, full1, ae1, af1, ovf1, unf1;

  int tests_run = 0;
  int tests_failed = 0;

  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] exp_q[$];
  bit               m_ovf;
  bit               m_unf;

  fifo_flex #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .count(count0), .empty(empty0), .full(full0),
    .almost_empty(ae0), .almost_full(af0), .overflow(ovf0), .underflow(unf0)
  );

  fifo_flex #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1'b1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .count(count1), .empty(empty1), .full(full1),
    .almost_empty(ae1), .almost_full(af1), .overflow(ovf1), .underflow(unf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_count"}, count0, 0);
    checkOutput({tag, "_empty"}, empty0, 1);
    checkOutput({tag, "_full"}, full0, 0);
    checkOutput({tag, "_ae"}, ae0, 1);
    checkOutput({tag, "_af"}, af0, 0);
    checkOutput({tag, "_rd_valid"}, rd_valid0, 0);
    checkOutput({tag, "_rd_data"}, rd_data0, 0);
    checkOutput({tag, "_ovf"}, ovf0, 0);
    checkOutput({tag, "_unf"}, unf0, 0);
    checkOutput({tag, "_fwft_rd_valid"}, rd_valid1, 0);
    checkOutput({tag, "_fwft_rd_data"}, rd_data1, 0);
    checkOutput({tag, "_fwft_count"}, count1, 0);
  endtask

  // One clock of stimulus: update the model, clock the DUTs, compare everything.
  task automatic applyStimulus(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit c);
    bit wa, ra;
    int sz;
    wa = w && (m_q.size() < DEPTH) && !c;
    ra = r && (m_q.size() > 0) && !c;
    if (c) begin
      m_q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      if (w && m_q.size() == DEPTH) m_ovf = 1;
      if (r && m_q.size() == 0) m_unf = 1;
    end
    if (ra) exp_q.push_back(m_q.pop_front());
    if (wa) m_q.push_back(d);

    wr_en = w; wr_data = d; rd_en = r; clr = c;
    @(posedge clk);
    #1;
    wr_en = 0; rd_en = 0; clr = 0;

    sz = m_q.size();
    checkOutput("count", count0, sz);
    checkOutput("count_fwft", count1, sz);
    checkOutput("empty", empty0, sz == 0);
    checkOutput("full", full0, sz == DEPTH);
    checkOutput("almost_empty", ae0, sz <= 1);
    checkOutput("almost_full", af0, sz >= 4);
    checkOutput("overflow", ovf0, m_ovf);
    checkOutput("underflow", unf0, m_unf);
    checkOutput("rd_valid", rd_valid0, ra);
    if (rd_valid0) begin
      if (exp_q.size() == 0) checkOutput("rd_extra", rd_valid0, 0);
      else checkOutput("rd_data", rd_data0, exp_q.pop_front());
    end
    checkOutput("fwft_rd_valid", rd_valid1, sz > 0);
    if (sz > 0) checkOutput("fwft_rd_data", rd_data1, m_q[0]);
  endtask

  initial begin
    rst_n = 0; clr = 0; wr_en = 0; rd_en = 0; wr_data = '0;
    m_ovf = 0; m_unf = 0;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst_n = 1;

    // Fill, overflow, drain in order.
    for (int i = 0; i < 5; i++) applyStimulus(1, 8'h11 + 8'(i), 0, 0);
    checkOutput("fill_full", full0, 1);
    applyStimulus(1, 8'h16, 0, 0);
    checkOutput("sixth_write_ovf", ovf0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 8'h00, 1, 0);
    applyStimulus(0, 8'h00, 0, 1);

    // Interleaved stream of 12 words across two pointer wraps.
    for (int i = 0; i < 3; i++) applyStimulus(1, 8'h20 + 8'(i), 0, 0);
    for (int i = 3; i < 12; i++) applyStimulus(1, 8'h20 + 8'(i), 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1, 0);

    // Simultaneous read/write at full and at empty.
    for (int i = 0; i < 5; i++) applyStimulus(1, 8'hC1 + 8'(i), 0, 0);
    applyStimulus(1, 8'hAA, 1, 0);
    checkOutput("full_rw_count", count0, 4);
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 1, 0);
    applyStimulus(1, 8'hBB, 1, 0);
    checkOutput("empty_rw_count", count0, 1);
    applyStimulus(0, 8'h00, 1, 0);
    checkOutput("empty_rw_data", rd_data0, 8'hBB);
    applyStimulus(0, 8'h00, 0, 1);

    // Underflow, then clr wins over a write.
    applyStimulus(0, 8'h00, 1, 0);
    checkOutput("underflow_set", unf0, 1);
    applyStimulus(1, 8'h77, 0, 1);
    checkOutput("clr_drops_write", count0, 0);
    checkOutput("clr_clears_unf", unf0, 0);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 3; i++) applyStimulus(1, 8'h40 + 8'(i), 0, 0);
    applyStimulus(0, 8'h00, 1, 0);
    applyStimulus(1, 8'h43, 0, 0);
    #2;
    rst_n = 0;
    #1;
    checkResetValues("async_reset");
    m_q.delete(); exp_q.delete(); m_ovf = 0; m_unf = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    applyStimulus(1, 8'h5A, 0, 0);
    applyStimulus(0, 8'h00, 1, 0);
    checkOutput("post_reset_data", rd_data0, 8'h5A);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 8'h00, 1, 0);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo_flex.md
FIFO_FLEX -- requirements
Module: fifo_flex

Interface
REQ-001 Parameter DEPTH, default 8: number of entries; any integer >= 2, not restricted to powers of two.
REQ-002 Parameter WIDTH, default 32: data word width in bits.
REQ-003 Parameter AF_LEVEL, default DEPTH-1: almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
REQ-004 Parameter AE_LEVEL, default 1: almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.
REQ-005 Parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 Derived CNTW = $clog2(DEPTH+1); PTRW = $clog2(DEPTH), minimum 1.
REQ-007 clk  input  1  single clock; all state updates on the rising edge.
REQ-008 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-009 clr  input  1  synchronous flush.
REQ-010 wr_en  input  1  write request.
REQ-011 wr_data  input  WIDTH  write word.
REQ-012 rd_en  input  1  read request (pop).
REQ-013 rd_data  output  WIDTH  read word.
REQ-014 rd_valid  output  1  rd_data holds a valid popped word (FWFT=0) or a valid head word (FWFT=1).
REQ-015 count  output  CNTW  current occupancy, 0..DEPTH.
REQ-016 empty, full, almost_empty, almost_full  output  1 each  status flags.
REQ-017 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-018 A write is accepted iff wr_en && !full && !clr; an accepted write stores wr_data at wr_ptr.
REQ-019 A read is accepted iff rd_en && !empty && !clr; an accepted read advances rd_ptr.
REQ-020 Pointers increment by one and wrap from DEPTH-1 to 0; no modulo-2^PTRW wrap.
REQ-021 count: +1 on write only, -1 on read only, unchanged on both or neither; it never exceeds DEPTH or underflows.
REQ-022 Simultaneous read and write when full: read accepted, write rejected, count becomes DEPTH-1.
REQ-023 Simultaneous read and write when empty: write accepted, read rejected, count becomes 1.
REQ-024 empty = (count == 0); full = (count == DEPTH); almost flags per REQ-003/004; all are decoded from registered count, with no combinational path from inputs.
REQ-025 FWFT=0: on an accepted read, rd_data is registered to mem[rd_ptr] and rd_valid = 1 on the next cycle; otherwise rd_valid = 0 next cycle and rd_data holds its last value.
REQ-026 FWFT=1: rd_data = mem[rd_ptr] and rd_valid = !empty; rd_en pops the presented word; read latency is zero.
REQ-027 Write-to-read latency: a word written at edge N is readable, with empty low, after edge N.
REQ-028 overflow is set on wr_en && full && !clr, and underflow is set on rd_en && empty && !clr; both hold until clr or reset.
REQ-029 clr has priority over wr_en and rd_en; next cycle: pointers 0, count 0, rd_valid 0, overflow 0, underflow 0; memory contents unchanged.
REQ-030 Data order is strict FIFO; no word is duplicated, lost or reordered across any number of pointer wraps.

Reset
REQ-031 While rst_n is low: pointers 0, count 0, empty 1, full 0, almost_empty 1 (if AE_LEVEL >= 0), almost_full 0, rd_valid 0, rd_data 0, overflow 0, underflow 0.
REQ-032 Memory array is not reset; reset asserted mid-operation discards all contents immediately, and the first post-reset read returns only newly written data.
REQ-033 Deassertion of rst_n is synchronous to clk externally; the block accepts wr_en on the first edge after deassertion.

Verification (DEPTH=5, WIDTH=8, AF_LEVEL=4, AE_LEVEL=1)
REQ-034 Write 0x11..0x15 -> count 5, full 1, almost_full from count 4; sixth write of 0x16 -> rejected, overflow 1; reads return 0x11..0x15 in order.
REQ-035 Stream 12 writes/reads interleaved across two pointer wraps -> output sequence equals input sequence exactly, and count never exceeds 5.
REQ-036 Full, then rd_en and wr_en (0xAA) together -> count 4, 0xAA absent from FIFO; empty, then both together (0xBB) -> count 1, next read returns 0xBB.
REQ-037 FWFT=0 read -> rd_valid pulses one cycle after rd_en; FWFT=1 -> rd_data = first written word in the cycle after the write, with rd_valid 1.
REQ-038 rd_en on empty -> underflow 1, count 0; then clr together with wr_en -> count 0, underflow 0, write dropped.
REQ-039 Assert rst_n low with count 3 mid-burst -> all outputs take reset values asynchronously; after release, write 0x5A and read -> 0x5A.
